// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared constants and width helpers for the register hazard scoreboard.
package reg_hazard_scoreboard_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    // Stage-select width: at least one bit even for a single tracked stage.
    function automatic int sel_w(input int depth);
        if (depth <= 1) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_hazard_scoreboard_if.sv
// Issue/compare bundle between the decode stage (master) and the scoreboard (slave).
interface reg_hazard_scoreboard_if
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = sel_w(DEPTH),
    parameter int CNT_W   = cnt_w(DEPTH)
);
    logic                      flush;
    logic                      issue_valid;
    logic                      issue_wen;
    logic                      issue_is_load;
    logic [ADDR_W-1:0]         issue_dest;
    logic [NUM_SRC-1:0]        src_used;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]        fwd_hit;
    logic [NUM_SRC*SEL_W-1:0]  fwd_stage;
    logic                      stall;
    logic [CNT_W-1:0]          occupancy;

    modport master (
        output flush, issue_valid, issue_wen, issue_is_load, issue_dest, src_used, src_addr,
        input  fwd_hit, fwd_stage, stall, occupancy
    );

    modport slave (
        input  flush, issue_valid, issue_wen, issue_is_load, issue_dest, src_used, src_addr,
        output fwd_hit, fwd_stage, stall, occupancy
    );
endinterface

// File: rtl/reg_hazard_scoreboard_addr_match_cell.sv
// One source-vs-entry address comparator; address 0 can be masked as the hardwired-zero register.
module addr_match_cell
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic [ADDR_W-1:0] i_a,
    input  logic [ADDR_W-1:0] i_b,
    input  logic              i_en,
    output logic              o_match
);
    localparam logic ZERO_MATCHES = (ZERO_HARDWIRED == 0) ? 1'b1 : 1'b0;

    logic w_nonzero_ok;

    assign w_nonzero_ok = ZERO_MATCHES | (i_a != ADDR_W'(ZERO_REG));
    assign o_match      = i_en & (i_a == i_b) & w_nonzero_ok;
endmodule

// File: rtl/reg_hazard_scoreboard.sv
// Destination-register scoreboard: shift pipeline of in-flight writers, per-source
// youngest-match forwarding select and a one-cycle load-use stall.
module reg_hazard_scoreboard
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DEPTH          = 3,
    parameter int NUM_SRC        = 2,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    reg_hazard_scoreboard_if.slave bus
);
    localparam int   SEL_W        = sel_w(DEPTH);
    localparam int   CNT_W        = cnt_w(DEPTH);
    localparam logic ZERO_MATCHES = (ZERO_HARDWIRED == 0) ? 1'b1 : 1'b0;

    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0]         r_is_load;
    logic [ADDR_W-1:0]        r_dest [DEPTH];

    logic [NUM_SRC*DEPTH-1:0] w_match;
    logic [NUM_SRC-1:0]       w_load_use;
    logic [NUM_SRC-1:0]       w_fwd_hit;
    logic [NUM_SRC*SEL_W-1:0] w_fwd_stage;
    logic                     w_stall;
    logic                     w_issue_wr;
    logic [CNT_W-1:0]         w_occupancy;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [SEL_W-1:0] w_sel;

        for (genvar gk = 0; gk < DEPTH; gk++) begin : g_entry
            addr_match_cell #(
                .ADDR_W         (ADDR_W),
                .ZERO_HARDWIRED (ZERO_HARDWIRED)
            ) u_cell (
                .i_a     (bus.src_addr[gi*ADDR_W +: ADDR_W]),
                .i_b     (r_dest[gk]),
                .i_en    (bus.src_used[gi] & r_valid[gk]),
                .o_match (w_match[gi*DEPTH + gk])
            );
        end

        // Priority encoder: scan oldest to youngest so the youngest match is left last.
        always_comb begin
            w_sel = {SEL_W{1'b0}};
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (w_match[gi*DEPTH + k]) begin
                    w_sel = SEL_W'(k);
                end else begin
                    w_sel = w_sel;
                end
            end
        end

        assign w_fwd_hit[gi]                   = |w_match[gi*DEPTH +: DEPTH];
        assign w_fwd_stage[gi*SEL_W +: SEL_W]  = w_sel;
        assign w_load_use[gi]                  = w_match[gi*DEPTH] & r_is_load[0];
    end

    assign w_stall    = |w_load_use;
    assign w_issue_wr = bus.issue_valid & bus.issue_wen &
                        (ZERO_MATCHES | (bus.issue_dest != ADDR_W'(ZERO_REG)));

    // Population count of valid entries.
    always_comb begin
        w_occupancy = {CNT_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            w_occupancy = w_occupancy + CNT_W'(r_valid[k]);
        end
    end

    // Entry pipeline: reset > flush > stall bubble > normal issue into entry 0.
    always_ff @(posedge i_clock) begin
        if (i_reset || bus.flush) begin
            r_valid   <= {DEPTH{1'b0}};
            r_is_load <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                r_dest[k] <= {ADDR_W{1'b0}};
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_is_load[k] <= r_is_load[k-1];
                r_dest[k]    <= r_dest[k-1];
            end
            if (w_stall) begin
                r_valid[0]   <= 1'b0;
                r_is_load[0] <= 1'b0;
                r_dest[0]    <= {ADDR_W{1'b0}};
            end else begin
                r_valid[0]   <= w_issue_wr;
                r_is_load[0] <= bus.issue_is_load;
                r_dest[0]    <= bus.issue_dest;
            end
        end
    end

    assign bus.fwd_hit   = w_fwd_hit;
    assign bus.fwd_stage = w_fwd_stage;
    assign bus.stall     = w_stall;
    assign bus.occupancy = w_occupancy;
endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed bench: two scoreboards (zero register hardwired and not) driven with identical stimulus.
module tb_reg_hazard_scoreboard;
    import reg_hazard_scoreboard_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    reg_hazard_scoreboard_if #(.ADDR_W(5), .DEPTH(3), .NUM_SRC(2)) bus_z1 ();
    reg_hazard_scoreboard_if #(.ADDR_W(5), .DEPTH(3), .NUM_SRC(2)) bus_z0 ();

    reg_hazard_scoreboard #(.ADDR_W(5), .DEPTH(3), .NUM_SRC(2), .ZERO_HARDWIRED(1)) dut_z1 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_z1)
    );

    reg_hazard_scoreboard #(.ADDR_W(5), .DEPTH(3), .NUM_SRC(2), .ZERO_HARDWIRED(0)) dut_z0 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_z0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic wen, input logic ld, input logic [4:0] dest);
        bus_z1.issue_valid = v;   bus_z0.issue_valid = v;
        bus_z1.issue_wen = wen;   bus_z0.issue_wen = wen;
        bus_z1.issue_is_load = ld; bus_z0.issue_is_load = ld;
        bus_z1.issue_dest = dest; bus_z0.issue_dest = dest;
    endtask

    task automatic set_src(input logic [1:0] used, input logic [4:0] s1, input logic [4:0] s0);
        bus_z1.src_used = used;       bus_z0.src_used = used;
        bus_z1.src_addr = {s1, s0};   bus_z0.src_addr = {s1, s0};
    endtask

    task automatic set_flush(input logic f);
        bus_z1.flush = f;
        bus_z0.flush = f;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        set_flush(1'b0);
        // Reset with random activity on every input
        for (int c = 0; c < 2; c++) begin
            set_issue(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
            set_src(2'($urandom), 5'($urandom), 5'($urandom));
            tick();
        end
        rst = 1'b0;
        set_issue(1'b0, 1'b0, 1'b0, 5'd0);
        set_src(2'b11, 5'd5, 5'd3);
        #1;
        chk("reset_hit",   32'(bus_z1.fwd_hit),   32'h0);
        chk("reset_stage", 32'(bus_z1.fwd_stage), 32'h0);
        chk("reset_stall", 32'(bus_z1.stall),     32'h0);
        chk("reset_occ",   32'(bus_z1.occupancy), 32'h0);
        chk("reset_occ_z0", 32'(bus_z0.occupancy), 32'h0);

        // ALU forwarding ages through stages 0,1,2 then retires
        set_src(2'b00, 5'd0, 5'd0);
        set_issue(1'b1, 1'b1, 1'b0, 5'd7);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0);
        set_src(2'b01, 5'd0, 5'd7);
        #1;
        chk("alu_hit_s0",   32'(bus_z1.fwd_hit),   32'h1);
        chk("alu_stage_s0", 32'(bus_z1.fwd_stage), 32'h0);
        chk("alu_occ",      32'(bus_z1.occupancy), 32'h1);
        tick();
        chk("alu_hit_s1",   32'(bus_z1.fwd_hit),   32'h1);
        chk("alu_stage_s1", 32'(bus_z1.fwd_stage), 32'h1);
        tick();
        chk("alu_stage_s2", 32'(bus_z1.fwd_stage), 32'h2);
        tick();
        chk("alu_retired",  32'(bus_z1.fwd_hit),   32'h0);
        chk("alu_occ_end",  32'(bus_z1.occupancy), 32'h0);

        // Load-use: one stall cycle, then forwarded from stage 1 and consumer accepted
        set_src(2'b00, 5'd0, 5'd0);
        set_issue(1'b1, 1'b1, 1'b1, 5'd4);
        tick();
        set_issue(1'b1, 1'b1, 1'b0, 5'd6);
        set_src(2'b10, 5'd4, 5'd0);
        #1;
        chk("lu_stall",     32'(bus_z1.stall),     32'h1);
        chk("lu_hit_stall", 32'(bus_z1.fwd_hit),   32'h2);
        chk("lu_stage_stall", 32'(bus_z1.fwd_stage), 32'h0);
        tick();
        chk("lu_stall_gone", 32'(bus_z1.stall),     32'h0);
        chk("lu_hit_fwd",    32'(bus_z1.fwd_hit),   32'h2);
        chk("lu_stage_fwd",  32'(bus_z1.fwd_stage), 32'h4);
        chk("lu_occ_bubble", 32'(bus_z1.occupancy), 32'h1);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0);
        set_src(2'b01, 5'd0, 5'd6);
        #1;
        chk("lu_accepted",  32'(bus_z1.fwd_hit),   32'h1);
        chk("lu_acc_stage", 32'(bus_z1.fwd_stage), 32'h0);
        chk("lu_acc_occ",   32'(bus_z1.occupancy), 32'h2);
        set_src(2'b00, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) tick();

        // Zero destination: masked only when hardwired
        set_issue(1'b1, 1'b1, 1'b0, 5'd0);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0);
        set_src(2'b01, 5'd0, 5'd0);
        #1;
        chk("zero_hit_hw",  32'(bus_z1.fwd_hit),   32'h0);
        chk("zero_occ_hw",  32'(bus_z1.occupancy), 32'h0);
        chk("zero_hit_nhw", 32'(bus_z0.fwd_hit),   32'h1);
        chk("zero_occ_nhw", 32'(bus_z0.occupancy), 32'h1);
        set_src(2'b00, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) tick();

        // Duplicate destinations: youngest wins
        set_issue(1'b1, 1'b1, 1'b0, 5'd9);
        tick();
        tick();
        set_issue(1'b1, 1'b0, 1'b0, 5'd9);
        set_src(2'b01, 5'd0, 5'd9);
        #1;
        chk("young_stage0", 32'(bus_z1.fwd_stage), 32'h0);
        chk("young_hit",    32'(bus_z1.fwd_hit),   32'h1);
        tick();
        chk("young_stage1", 32'(bus_z1.fwd_stage), 32'h1);
        chk("young_occ",    32'(bus_z1.occupancy), 32'h2);
        set_issue(1'b0, 1'b0, 1'b0, 5'd0);
        set_src(2'b00, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) tick();

        // Flush with a coincident issue drops everything
        for (int d = 1; d <= 3; d++) begin
            set_issue(1'b1, 1'b1, 1'b0, 5'(d));
            tick();
        end
        chk("fill_occ", 32'(bus_z1.occupancy), 32'h3);
        set_flush(1'b1);
        set_issue(1'b1, 1'b1, 1'b0, 5'd2);
        tick();
        set_flush(1'b0);
        set_issue(1'b0, 1'b0, 1'b0, 5'd0);
        set_src(2'b01, 5'd0, 5'd2);
        #1;
        chk("flush_occ", 32'(bus_z1.occupancy), 32'h0);
        chk("flush_hit", 32'(bus_z1.fwd_hit),   32'h0);

        // Reset mid-stream
        set_issue(1'b1, 1'b1, 1'b1, 5'd5);
        set_src(2'b00, 5'd0, 5'd0);
        tick();
        set_issue(1'b0, 1'b0, 1'b0, 5'd0);
        set_src(2'b01, 5'd0, 5'd5);
        #1;
        chk("pre_rst_stall", 32'(bus_z1.stall), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_occ",   32'(bus_z1.occupancy), 32'h0);
        chk("mid_rst_stall", 32'(bus_z1.stall),     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_hazard_scoreboard.md
Name: reg_hazard_scoreboard

Overview:
- Parametrised successor to the 5-bit register-address equality compare.
- Tracks destination register addresses of in-flight instructions in a DEPTH-entry shift pipeline.
- Compares NUM_SRC source addresses against every tracked entry each cycle.
- Produces per-source forwarding hits with youngest-match stage select, plus a load-use stall; sits in the decode/issue stage of the CPU pipeline.

Parameters:
- ADDR_W, 5, register address width.
- DEPTH, 3, tracked in-flight stages (entry 0 = youngest); legal range 1..8.
- NUM_SRC, 2, source operands compared per cycle; legal range 1..4.
- ZERO_HARDWIRED, 1, when 1, address 0 never matches (hardwired-zero register).

Ports:
- clock, input, 1, sole clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high; clears all entries.
- flush, input, 1, synchronous clear of all entries (branch/exception squash).
- issue_valid, input, 1, an instruction is presented for issue this cycle.
- issue_wen, input, 1, presented instruction writes a register.
- issue_is_load, input, 1, presented instruction is a load.
- issue_dest, input, ADDR_W, destination address of presented instruction.
- src_used, input, NUM_SRC, per-source enable; bit i qualifies source i.
- src_addr, input, NUM_SRC*ADDR_W, packed source addresses; source i at [i*ADDR_W +: ADDR_W].
- fwd_hit, output, NUM_SRC, source i matches a valid in-flight entry.
- fwd_stage, output, NUM_SRC*SEL_W, index of youngest matching entry per source; SEL_W = max(1, clog2(DEPTH)).
- stall, output, 1, load-use hazard; issue blocked this cycle.
- occupancy, output, clog2(DEPTH+1), count of valid entries (registered-state derived).

Behaviour:
- Entry state: valid, dest[ADDR_W], is_load. Reset or flush: all valid=0, dest=0, is_load=0, so occupancy=0, fwd_hit=0, fwd_stage=0, stall=0.
- Match(i,k) = src_used[i] & entry[k].valid & (src_addr_i == entry[k].dest) & (addr != 0 or ZERO_HARDWIRED==0).
- fwd_hit[i] = OR over k of Match(i,k). fwd_stage_i = lowest k with Match(i,k), else 0. Combinational from inputs and current state; zero-cycle latency.
- stall = OR over i of (Match(i,0) & entry[0].is_load). Combinational. fwd outputs still reported during stall; the consumer ignores them.
- Each rising edge, with no reset/flush: entry[k] <= entry[k-1] for k=1..DEPTH-1; entry[DEPTH-1] retires.
- Entry 0 load: if stall=1, entry 0 <= bubble (valid=0), and the presented instruction is not accepted and is re-presented by upstream.
- Otherwise entry 0 <= {issue_valid & issue_wen & (issue_dest!=0 or ZERO_HARDWIRED==0), issue_dest, issue_is_load}.
- Priority: reset > flush > stall > normal shift. Flush coincident with issue_valid drops the issued instruction.
- Stall lasts exactly one cycle per load-use: after the bubble, the load sits in entry 1 and is forwardable.
- Duplicate dests across entries are legal; youngest wins.
- Reset mid-stream discards all entries; no outputs are X after the first reset edge.

Decomposition:
- Shared package holds the default constants: ADDR_W=5 and ZERO_REG=0, plus the SEL_W clog2 function.
- One natural sub-module: addr_match_cell. It takes ADDR_W-wide a, b and en, and outputs match = en & (a==b) & nonzero-qualifier. It is instanced NUM_SRC*DEPTH times in a generate loop.
- Priority encoder and shift pipeline stay in the top.

Test Plan:
- Reset/idle: reset=1 for 2 cycles with random inputs, then src_addr={5,3}, src_used=2'b11 -> fwd_hit=0, stall=0, occupancy=0.
- ALU forwarding: issue dest=7 (non-load); next cycle src0=7 -> fwd_hit[0]=1, fwd_stage=0. One cycle later -> stage 1. After DEPTH+1 cycles -> hit=0.
- Load-use: issue load dest=4, then src1=4 -> stall=1 for exactly one cycle. Next cycle stall=0, fwd_hit[1]=1, fwd_stage=1, and the new instruction is accepted.
- Zero register: issue dest=0 with wen=1, src0=0 -> fwd_hit=0 and occupancy unchanged. Repeat with ZERO_HARDWIRED=0 -> fwd_hit[0]=1.
- Youngest priority: issue dest=9 twice consecutively, src0=9 -> fwd_stage=0 (not 1). Issue a third instruction with wen=0 -> fwd_stage=1.
- Flush: fill DEPTH entries, assert flush with issue_valid=1 dest=2 -> next cycle occupancy=0 and src=2 gives fwd_hit=0.
